// File: rtl/rvv_backend_retire_buf.sv
// Retire buffer between the ROB and the register files. Retiring uops are
// accepted into a small circular FIFO and drained in order onto up to NUM_WR
// VRF write ports or the single scalar (XRF) write-back port.
//
// Handshake: a ROB lane transfers when rd_valid_rob2rt[i] && rd_ready_rt2rob[i]
// at a rising clk edge. The ready only reflects free space at the start of the
// cycle. The VRF ports have no ready and always accept. The XRF port transfers
// on wr_valid_rt2xrf && wr_ready_xrf2rt. Its valid may rise while ready is low,
// and it holds until the transfer.
module rvv_backend_retire_buf #(
  parameter int NUM_RT = 4,
  parameter int NUM_WR = 2,
  localparam int RT_W = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_RT-1:0]     rd_valid_rob2rt,
  input  logic [NUM_RT*RT_W-1:0] rd_rob2rt,
  output logic [NUM_RT-1:0]     rd_ready_rt2rob,
  output logic [NUM_WR-1:0]     wr_valid_rt2vrf,
  output logic [NUM_WR*5-1:0]   wr_index_rt2vrf,
  output logic [NUM_WR*128-1:0] wr_data_rt2vrf,
  output logic [NUM_WR*16-1:0]  wr_strobe_rt2vrf,
  output logic                  wr_valid_rt2xrf,
  output logic [31:0]           wr_data_rt2xrf,
  input  logic                  wr_ready_xrf2rt,
  output logic                  vxsat_set_rt2csr,
  output logic                  trap_done_rt2rvs
);
  // Lane payload layout, MSB first:
  //   w_valid[199] w_index[198:194] w_data[193:66] w_type[65]
  //   vd_type strobe[64:49] trap_flag[48] vector_csr[47:16] vxsaturate[15:0]
  localparam int PW = (NUM_RT > 1) ? $clog2(NUM_RT) : 1;
  localparam int CW = $clog2(NUM_RT + 1);

  // vector_csr is not needed after retirement, so it is not stored.
  typedef struct packed {
    logic         w_valid;
    logic [4:0]   w_index;
    logic [127:0] w_data;
    logic         w_type;
    logic [15:0]  strobe;
    logic         trap;
    logic [15:0]  vxsat;
  } entry_t;

  entry_t          mem [NUM_RT];
  entry_t          lane [NUM_RT];
  entry_t          slot [NUM_WR];
  logic [PW-1:0]   slot_idx [NUM_WR];
  logic [PW-1:0]   lane_slot [NUM_RT];
  logic [NUM_RT-1:0] acc;
  logic [PW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d, n_acc, n_pop;
  logic            vxsat_q, vxsat_d, trap_q, trap_d;
  logic            unused_csr;

  for (genvar i = 0; i < NUM_RT; i++) begin : g_lane
    assign lane[i] = {rd_rob2rt[i*RT_W+49 +: 151], rd_rob2rt[i*RT_W+48],
                      rd_rob2rt[i*RT_W +: 16]};
  end

  for (genvar k = 0; k < NUM_WR; k++) begin : g_slot
    assign slot_idx[k] = PW'((int'(rptr_q) + k) % NUM_RT);
    assign slot[k]     = mem[slot_idx[k]];
  end

  // Fold the discarded vector_csr bits so they are visibly consumed.
  always_comb begin
    unused_csr = 1'b0;
    for (int i = 0; i < NUM_RT; i++) unused_csr = unused_csr ^ (^rd_rob2rt[i*RT_W+16 +: 32]);
  end

  // Credit from start-of-cycle occupancy; accepted lanes packed from wptr.
  always_comb begin
    n_acc = '0;
    for (int i = 0; i < NUM_RT; i++) begin
      rd_ready_rt2rob[i] = (NUM_RT - int'(count_q)) > i;
      acc[i]       = rd_valid_rob2rt[i] & rd_ready_rt2rob[i];
      lane_slot[i] = PW'((int'(wptr_q) + int'(n_acc)) % NUM_RT);
      if (acc[i]) n_acc = n_acc + CW'(1);
    end
  end

  // In-order drain: once a slot stalls, no younger slot may pop.
  always_comb begin
    logic        blocked;
    logic        pop;
    logic [15:0] vx_acc;
    blocked          = 1'b0;
    vx_acc           = '0;
    n_pop            = '0;
    trap_d           = 1'b0;
    wr_valid_rt2vrf  = '0;
    wr_index_rt2vrf  = '0;
    wr_data_rt2vrf   = '0;
    wr_strobe_rt2vrf = '0;
    wr_valid_rt2xrf  = 1'b0;
    wr_data_rt2xrf   = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      pop = 1'b0;
      if (!blocked && (int'(count_q) > k)) begin
        if (slot[k].trap) begin
          // A trapped uop leaves alone from the head and writes nothing.
          if (k == 0) begin
            pop    = 1'b1;
            trap_d = 1'b1;
          end
          blocked = 1'b1;
        end else if (slot[k].w_type) begin
          // Scalar write-back exists only at the head.
          if (k == 0) begin
            wr_valid_rt2xrf = 1'b1;
            wr_data_rt2xrf  = slot[k].w_data[31:0];
            pop     = wr_ready_xrf2rt;
            blocked = !wr_ready_xrf2rt;
          end else begin
            blocked = 1'b1;
          end
        end else begin
          pop = 1'b1;
          // Two writes to one register in one cycle would lose WAW order.
          for (int j = 0; j < k; j++) begin
            if (wr_valid_rt2vrf[j] && slot[k].w_valid &&
                wr_index_rt2vrf[j*5 +: 5] == slot[k].w_index) pop = 1'b0;
          end
          blocked = !pop;
          if (pop) begin
            vx_acc = vx_acc | (slot[k].vxsat & slot[k].strobe);
            if (slot[k].w_valid) begin
              wr_valid_rt2vrf[k]          = 1'b1;
              wr_index_rt2vrf[k*5 +: 5]   = slot[k].w_index;
              wr_data_rt2vrf[k*128 +: 128] = slot[k].w_data;
              wr_strobe_rt2vrf[k*16 +: 16] = slot[k].strobe;
            end
          end
        end
      end else begin
        blocked = 1'b1;
      end
      if (pop) n_pop = n_pop + CW'(1);
    end
    vxsat_d = |vx_acc;
  end

  // Next pointers and occupancy.
  always_comb begin
    rptr_d  = PW'((int'(rptr_q) + int'(n_pop)) % NUM_RT);
    wptr_d  = PW'((int'(wptr_q) + int'(n_acc)) % NUM_RT);
    count_d = count_q + n_acc - n_pop;
  end

  // Control state; reset drops every buffered uop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      vxsat_q <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      vxsat_q <= vxsat_d;
      trap_q  <= trap_d;
    end
  end

  // Payload storage; contents are meaningless unless counted, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RT; i++) begin
      if (acc[i]) mem[lane_slot[i]] <= lane[i];
    end
  end

  assign vxsat_set_rt2csr = vxsat_q;
  assign trap_done_rt2rvs = trap_q;
endmodule

// File: tb/tb_rvv_backend_retire_buf.sv
// Directed bench for the retire buffer: burst, WAW, XRF stall, trap,
// vxsat and reset while occupied.
module tb_rvv_backend_retire_buf;
  localparam int NUM_RT = 4;
  localparam int NUM_WR = 2;
  localparam int RT_W   = 200;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_RT-1:0]      rd_valid = '0;
  logic [NUM_RT*RT_W-1:0] rd_data = '0;
  logic [NUM_RT-1:0]      rd_ready;
  logic [NUM_WR-1:0]      wr_valid;
  logic [NUM_WR*5-1:0]    wr_index;
  logic [NUM_WR*128-1:0]  wr_data;
  logic [NUM_WR*16-1:0]   wr_strobe;
  logic                   xrf_valid;
  logic [31:0]            xrf_data;
  logic                   xrf_ready = 1'b1;
  logic                   vxsat_set;
  logic                   trap_done;

  int compared = 0;
  int mismatched = 0;

  rvv_backend_retire_buf #(.NUM_RT(NUM_RT), .NUM_WR(NUM_WR)) dut (
    .clk(clk), .rst(rst),
    .rd_valid_rob2rt(rd_valid), .rd_rob2rt(rd_data), .rd_ready_rt2rob(rd_ready),
    .wr_valid_rt2vrf(wr_valid), .wr_index_rt2vrf(wr_index),
    .wr_data_rt2vrf(wr_data), .wr_strobe_rt2vrf(wr_strobe),
    .wr_valid_rt2xrf(xrf_valid), .wr_data_rt2xrf(xrf_data),
    .wr_ready_xrf2rt(xrf_ready),
    .vxsat_set_rt2csr(vxsat_set), .trap_done_rt2rvs(trap_done)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic logic [RT_W-1:0] mk(input logic wv, input logic [4:0] idx,
      input logic [127:0] d, input logic wt, input logic [15:0] strb,
      input logic trap, input logic [15:0] vx);
    return {wv, idx, d, wt, strb, trap, 32'hA5A5_0000, vx};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state.
    #2;
    chk("rst_ready", 256'(rd_ready), 256'(4'b1111));
    chk("rst_wvalid", 256'(wr_valid), 256'(2'b00));
    chk("rst_pulses", 256'({xrf_valid, vxsat_set, trap_done}), 256'(3'b000));
    step();
    rst = 1'b0;
    step();

    // Full burst: v1..v4 in one cycle.
    rd_valid = 4'b1111;
    for (int i = 0; i < 4; i++)
      rd_data[i*RT_W +: RT_W] = mk(1'b1, 5'(i + 1), 128'(32'h1000 + i), 1'b0, 16'hFFFF, 1'b0, 16'h0);
    chk("burst_c0_ready", 256'(rd_ready), 256'(4'b1111));
    chk("burst_c0_wvalid", 256'(wr_valid), 256'(2'b00));
    step();
    rd_valid = '0;
    chk("burst_c1_ready", 256'(rd_ready), 256'(4'b0000));
    chk("burst_c1_wvalid", 256'(wr_valid), 256'(2'b11));
    chk("burst_c1_index", 256'(wr_index), 256'({5'd2, 5'd1}));
    chk("burst_c1_data", 256'(wr_data), {128'h1001, 128'h1000});
    chk("burst_c1_strobe", 256'(wr_strobe), 256'(32'hFFFF_FFFF));
    step();
    chk("burst_c2_ready", 256'(rd_ready), 256'(4'b0011));
    chk("burst_c2_wvalid", 256'(wr_valid), 256'(2'b11));
    chk("burst_c2_index", 256'(wr_index), 256'({5'd4, 5'd3}));
    step();
    chk("burst_c3_wvalid", 256'(wr_valid), 256'(2'b00));
    chk("burst_c3_ready", 256'(rd_ready), 256'(4'b1111));
    chk("burst_c3_vxsat", 256'(vxsat_set), 256'(1'b0));

    // WAW: two writes to v5.
    rd_valid = 4'b0011;
    rd_data[0 +: RT_W]    = mk(1'b1, 5'd5, 128'hAAAA, 1'b0, 16'hFFFF, 1'b0, 16'h0);
    rd_data[RT_W +: RT_W] = mk(1'b1, 5'd5, 128'hBBBB, 1'b0, 16'hFFFF, 1'b0, 16'h0);
    step();
    rd_valid = '0;
    chk("waw_c1_wvalid", 256'(wr_valid), 256'(2'b01));
    chk("waw_c1_data", 256'(wr_data[127:0]), 256'(128'hAAAA));
    step();
    chk("waw_c2_wvalid", 256'(wr_valid), 256'(2'b01));
    chk("waw_c2_index", 256'(wr_index[4:0]), 256'(5'd5));
    chk("waw_c2_data", 256'(wr_data[127:0]), 256'(128'hBBBB));
    step();
    chk("waw_c3_wvalid", 256'(wr_valid), 256'(2'b00));

    // Scalar at slot 1 waits behind a VRF write.
    rd_valid = 4'b0011;
    rd_data[0 +: RT_W]    = mk(1'b1, 5'd7, 128'h77, 1'b0, 16'h00FF, 1'b0, 16'h0);
    rd_data[RT_W +: RT_W] = mk(1'b1, 5'd0, 128'h1234_5678, 1'b1, 16'h0, 1'b0, 16'h0);
    step();
    rd_valid = '0;
    chk("xs1_c1_wvalid", 256'(wr_valid), 256'(2'b01));
    chk("xs1_c1_xvalid", 256'(xrf_valid), 256'(1'b0));
    step();
    chk("xs1_c2_xvalid", 256'(xrf_valid), 256'(1'b1));
    chk("xs1_c2_xdata", 256'(xrf_data), 256'(32'h1234_5678));
    chk("xs1_c2_wvalid", 256'(wr_valid), 256'(2'b00));
    step();
    chk("xs1_c3_xvalid", 256'(xrf_valid), 256'(1'b0));

    // XRF stall for three cycles, then pop.
    xrf_ready = 1'b0;
    rd_valid = 4'b0001;
    rd_data[0 +: RT_W] = mk(1'b1, 5'd0, {96'h0, 32'hCAFE_F00D}, 1'b1, 16'h0, 1'b0, 16'h0);
    step();
    rd_valid = '0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("stall_c%0d_xvalid", c), 256'(xrf_valid), 256'(1'b1));
      chk($sformatf("stall_c%0d_ready", c), 256'(rd_ready), 256'(4'b0111));
      step();
    end
    xrf_ready = 1'b1;
    #1;
    chk("stall_c4_xvalid", 256'(xrf_valid), 256'(1'b1));
    chk("stall_c4_xdata", 256'(xrf_data), 256'(32'hCAFE_F00D));
    step();
    chk("stall_c5_xvalid", 256'(xrf_valid), 256'(1'b0));
    chk("stall_c5_ready", 256'(rd_ready), 256'(4'b1111));

    // Trap at head, VRF write behind it.
    rd_valid = 4'b0011;
    rd_data[0 +: RT_W]    = mk(1'b1, 5'd9, 128'h99, 1'b0, 16'hFFFF, 1'b1, 16'hFFFF);
    rd_data[RT_W +: RT_W] = mk(1'b1, 5'd10, 128'h1010, 1'b0, 16'hFFFF, 1'b0, 16'h0);
    step();
    rd_valid = '0;
    chk("trap_c1_wvalid", 256'(wr_valid), 256'(2'b00));
    chk("trap_c1_xvalid", 256'(xrf_valid), 256'(1'b0));
    chk("trap_c1_done", 256'(trap_done), 256'(1'b0));
    step();
    chk("trap_c2_done", 256'(trap_done), 256'(1'b1));
    chk("trap_c2_vxsat", 256'(vxsat_set), 256'(1'b0));
    chk("trap_c2_wvalid", 256'(wr_valid), 256'(2'b01));
    chk("trap_c2_index", 256'(wr_index[4:0]), 256'(5'd10));
    step();
    chk("trap_c3_done", 256'(trap_done), 256'(1'b0));

    // vxsat masked by a zero strobe.
    rd_valid = 4'b0001;
    rd_data[0 +: RT_W] = mk(1'b1, 5'd11, 128'h11, 1'b0, 16'h0000, 1'b0, 16'h0001);
    step();
    rd_valid = '0;
    chk("vx0_c1_wvalid", 256'(wr_valid), 256'(2'b01));
    chk("vx0_c1_strobe", 256'(wr_strobe[15:0]), 256'(16'h0000));
    step();
    chk("vx0_c2_pulse", 256'(vxsat_set), 256'(1'b0));

    // vxsat with matching strobe.
    rd_valid = 4'b0001;
    rd_data[0 +: RT_W] = mk(1'b1, 5'd11, 128'h11, 1'b0, 16'h0001, 1'b0, 16'h0001);
    step();
    rd_valid = '0;
    chk("vx1_c1_pulse", 256'(vxsat_set), 256'(1'b0));
    step();
    chk("vx1_c2_pulse", 256'(vxsat_set), 256'(1'b1));
    step();
    chk("vx1_c3_pulse", 256'(vxsat_set), 256'(1'b0));

    // w_valid=0 VRF entry pops silently.
    rd_valid = 4'b0001;
    rd_data[0 +: RT_W] = mk(1'b0, 5'd12, 128'h12, 1'b0, 16'hFFFF, 1'b0, 16'h0);
    step();
    rd_valid = '0;
    chk("nowr_c1_wvalid", 256'(wr_valid), 256'(2'b00));
    chk("nowr_c1_ready", 256'(rd_ready), 256'(4'b0111));
    step();
    chk("nowr_c2_ready", 256'(rd_ready), 256'(4'b1111));

    // Reset while three uops are buffered.
    rd_valid = 4'b0111;
    for (int i = 0; i < 3; i++)
      rd_data[i*RT_W +: RT_W] = mk(1'b1, 5'(13 + i), 128'(i), 1'b0, 16'hFFFF, 1'b0, 16'hFFFF);
    step();
    rd_valid = '0;
    chk("rstm_pre_ready", 256'(rd_ready), 256'(4'b0001));
    #2;
    rst = 1'b1;
    #1;
    chk("rstm_ready", 256'(rd_ready), 256'(4'b1111));
    chk("rstm_wvalid", 256'(wr_valid), 256'(2'b00));
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rstm_after%0d_wvalid", c), 256'(wr_valid), 256'(2'b00));
      chk($sformatf("rstm_after%0d_ready", c), 256'(rd_ready), 256'(4'b1111));
      chk($sformatf("rstm_after%0d_vxsat", c), 256'(vxsat_set), 256'(1'b0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/rvv_backend_retire_buf.md
RVV_BACKEND_RETIRE_BUF -- requirements
Module: rvv_backend_retire_buf

Interface
REQ-001 SHALL take parameter NUM_RT, default 4: number of retire lanes from the ROB and the buffer depth in entries.
REQ-002 SHALL take parameter NUM_WR, default 2: number of VRF write ports.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rd_valid_rob2rt, input, NUM_RT bits: per-lane retire valid; always a contiguous prefix from lane 0.
REQ-006 SHALL have port rd_rob2rt, input, NUM_RT x ROB2RT_t: per-lane retire payload (w_valid, w_index[4:0], w_data[127:0], w_type, vd_type strobe[15:0], trap_flag, vector_csr, vxsaturate[15:0]).
REQ-007 SHALL have port rd_ready_rt2rob, output, NUM_RT bits: per-lane accept.
REQ-008 SHALL have ports wr_valid_rt2vrf (output, NUM_WR bits), wr_index_rt2vrf (output, NUM_WR x 5), wr_data_rt2vrf (output, NUM_WR x 128) and wr_strobe_rt2vrf (output, NUM_WR x 16): VRF write ports; always accepted by the VRF.
REQ-009 SHALL have ports wr_valid_rt2xrf (output, 1), wr_data_rt2xrf (output, 32) and wr_ready_xrf2rt (input, 1): scalar write-back with handshake.
REQ-010 SHALL have port vxsat_set_rt2csr, output, 1 bit: registered one-cycle pulse that sets vxsat.
REQ-011 SHALL have port trap_done_rt2rvs, output, 1 bit: registered one-cycle pulse when a trapped uop is retired.

Function
REQ-012 SHALL hold accepted uops in a NUM_RT-entry circular FIFO with rptr, wptr and count; pointers SHALL wrap modulo NUM_RT.
REQ-013 SHALL drive rd_ready_rt2rob[i] = (NUM_RT - count) > i, where count is the value at the start of the cycle; same-cycle pops SHALL NOT add credit.
REQ-014 SHALL accept lane i only when rd_valid[i] and rd_ready[i] are both high, and SHALL write accepted lanes in lane order starting at wptr.
REQ-015 SHALL make a uop accepted in cycle N visible at the FIFO head no earlier than cycle N+1; minimum accept-to-write latency is 1 cycle.
REQ-016 SHALL examine up to NUM_WR oldest entries (head+0, head+1) each cycle and pop them strictly in order; slot k pops only if slot k-1 pops in the same cycle.
REQ-017 SHALL, for a VRF entry (w_type=0, w_valid=1), drive port k with its index, data and vd_type strobe, and pop it.
REQ-018 SHALL pop a VRF entry with w_valid=0 without asserting any write port.
REQ-019 SHALL, for a scalar entry (w_type=1), pop it only at slot 0 and only when wr_ready_xrf2rt=1, driving w_data[31:0]; a scalar entry at slot 1 SHALL wait.
REQ-020 SHALL NOT pop the slot-1 entry in the same cycle as slot 0 when both are VRF writes to the same w_index; it SHALL pop the next cycle (WAW order preserved).
REQ-021 SHALL pop an entry with trap_flag=1 only at slot 0 and alone, perform no VRF or XRF write for it, and pulse trap_done_rt2rvs in the following cycle.
REQ-022 SHALL, in the cycle after any pop, pulse vxsat_set_rt2csr if OR over popped VRF entries of (vxsaturate & vd_type strobe) is non-zero.
REQ-023 SHALL update count = count + accepted - popped; simultaneous push and pop at count = NUM_RT SHALL be legal, with the pop freeing space for the next cycle only.
REQ-024 SHALL hold all write-port valids low when count = 0.

Reset
REQ-025 SHALL, while rst=1, immediately force count, rptr and wptr to 0, all rd_ready high, and all write valids, vxsat_set_rt2csr and trap_done_rt2rvs low; FIFO data is not reset.
REQ-026 SHALL discard all buffered uops, with no further writes, when rst asserts mid-operation.

Verification
REQ-027 SHALL be verified for full burst: 4 VRF uops, indices 1-4, accepted in cycle 0 -> cycle 1 writes v1/v2, cycle 2 writes v3/v4; rd_ready = 0000 in cycle 1 and 0011 in cycle 2.
REQ-028 SHALL be verified for WAW: 2 uops both to v5 (data A then B) -> A written in cycle 1 and B in cycle 2, on port 0 both times.
REQ-029 SHALL be verified for XRF stall: scalar uop at head with wr_ready_xrf2rt low for 3 cycles -> no pops during the stall; pop on the 4th cycle with data[31:0] driven.
REQ-030 SHALL be verified for trap: head uop with trap_flag=1 -> no write, trap_done_rt2rvs pulses exactly once the cycle after the pop.
REQ-031 SHALL be verified for vxsat: vxsaturate=0x0001 with strobe=0x0000 -> no pulse; with strobe=0x0001 -> one-cycle pulse.
REQ-032 SHALL be verified for reset mid-stream: rst while count = 3 -> count 0 and rd_ready = 1111 the same cycle, with no writes after rst deasserts.
